aes_sideband_fifo: RTL

Parametrised sideband FIFO that carries the per-block bypass text and the framing flags (new, last) of each block alongside the `aes_api` pipeline. It presents them at the output aligned with the core's `o_cp_ready`.

- Generalises the fixed-width bypass path to configurable width and depth.
- Adds two output modes (show-ahead or registered).
- Adds framing checking, frame counting, occupancy reporting and sticky error flags.

It sits between the block source and the core. Pushes occur with plaintext acceptance; pops are driven by `o_cp_ready`.

---
 rtl/aes_sideband_fifo.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_sideband_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_sideband_fifo
// Purpose  : Sideband FIFO carrying per-block bypass text plus new/last
//            framing flags alongside the aes_api pipeline. Pushes occur on
//            plaintext acceptance, pops are driven by the core's o_cp_ready.
//            Offers a show-ahead or registered output, framing checks,
//            completed-frame counting, occupancy and sticky error flags.
// Ports    : clk, rst_n (async, active-low), i_clear (sync flush)
//            i_push/i_new/i_last/i_bypass_text : write side
//            i_pop                             : consume head entry
//            o_bypass_text/o_new/o_last/o_valid: read side
//            o_count/o_full/o_empty            : occupancy
//            o_overflow/o_underflow/o_frame_err: sticky errors
//            o_frames                          : completed messages popped
// Revision : 1.0 - initial release
// ============================================================================
module aes_sideband_fifo #(
    parameter int DATA_W  = 289,
    parameter int DEPTH   = 16,
    parameter int OUT_REG = 0,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_new,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_bypass_text,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_bypass_text,
    output logic              o_new,
    output logic              o_last,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_frame_err,
    output logic [15:0]       o_frames
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam int               c_ENT_W     = DATA_W + 2;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    // Entry layout: {last, new, payload}
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    state_t             r_state;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_frame_err;
    logic [15:0]        r_frames;

    logic [c_ENT_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_wr_en;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    // No fall-through: a pop on an empty FIFO is never satisfied by a
    // same-cycle push. A pop on a full FIFO frees a slot for the push.
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_wr_en   = w_push_ok && !i_clear;

    // Storage is deliberately left unreset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {i_last, i_new, i_bypass_text};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_frames    <= '0;
        end else if (i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_frames    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (i_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop_ok && w_head[c_ENT_W-1]) begin
                r_frames <= r_frames + 16'd1;
            end
        end
    end

    // Framing checker: tracks message boundaries on accepted pushes only.
    // Offending entries are still stored; only the sticky flag records it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b0;
        end else if (i_clear) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b0;
        end else if (w_push_ok) begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_new) begin
                        r_frame_err <= 1'b1;
                    end else if (!i_last) begin
                        r_state <= ST_IN_FRAME;
                    end
                end
                ST_IN_FRAME: begin
                    // A new flag mid-message is a restart: flagged, frame kept open.
                    if (i_new) begin
                        r_frame_err <= 1'b1;
                    end else if (i_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (OUT_REG == 0) begin : g_show_ahead
            assign o_bypass_text = w_head[DATA_W-1:0];
            assign o_new         = w_head[DATA_W];
            assign o_last        = w_head[DATA_W+1];
            assign o_valid       = !w_empty;
        end else begin : g_out_reg
            logic [DATA_W-1:0] r_out_data;
            logic              r_out_new;
            logic              r_out_last;
            logic              r_out_valid;

            // Valid is a one-cycle strobe after each accepted pop; data holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_data  <= '0;
                    r_out_new   <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_valid <= 1'b0;
                end else if (i_clear) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_out_data <= w_head[DATA_W-1:0];
                        r_out_new  <= w_head[DATA_W];
                        r_out_last <= w_head[DATA_W+1];
                    end
                end
            end

            assign o_bypass_text = r_out_data;
            assign o_new         = r_out_new;
            assign o_last        = r_out_last;
            assign o_valid       = r_out_valid;
        end
    endgenerate

    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
    assign o_frame_err = r_frame_err;
    assign o_frames    = r_frames;

endmodule
`default_nettype wire
